// File: rtl/etx_pkg.sv
// Shared emesh packet layout and source indices for the elink TX arbiter.
package etx_pkg;

  localparam int PW = 104;
  localparam int CW = 4;

  localparam int WRITE_BIT = 0;
  localparam int DM_LSB    = 1;
  localparam int CTRL_LSB  = 3;
  localparam int DST_LSB   = 7;
  localparam int DATA_LSB  = 39;
  localparam int SRC_LSB   = 71;
  localparam int RSVD_BIT  = 103;

  localparam int NSRC = 3;

  localparam logic [1:0] SRC_RR = 2'd0;
  localparam logic [1:0] SRC_RQ = 2'd1;
  localparam logic [1:0] SRC_WR = 2'd2;

  // Pointer value after granting a source: the next source in rotation.
  function automatic logic [1:0] ptr_after(input logic [1:0] src);
    return (src == SRC_WR) ? SRC_RR : src + 2'd1;
  endfunction

endpackage

// File: rtl/etx_rr_arb.sv
// 3-way round-robin core: one-hot grant, search starts at the pointer.
module etx_rr_arb
  import etx_pkg::*;
(
  input  logic [NSRC-1:0] i_req,
  input  logic            i_en,
  input  logic [1:0]      i_ptr,
  output logic [NSRC-1:0] o_grant
);

  logic [1:0] w_ptr;

  // Pointer value 3 never occurs in normal operation; fold it onto rr.
  assign w_ptr = (i_ptr == 2'd3) ? SRC_RR : i_ptr;

  always_comb begin
    o_grant = '0;
    if (i_en) begin
      case (w_ptr)
        SRC_RQ: begin
          if      (i_req[SRC_RQ]) o_grant[SRC_RQ] = 1'b1;
          else if (i_req[SRC_WR]) o_grant[SRC_WR] = 1'b1;
          else if (i_req[SRC_RR]) o_grant[SRC_RR] = 1'b1;
        end
        SRC_WR: begin
          if      (i_req[SRC_WR]) o_grant[SRC_WR] = 1'b1;
          else if (i_req[SRC_RR]) o_grant[SRC_RR] = 1'b1;
          else if (i_req[SRC_RQ]) o_grant[SRC_RQ] = 1'b1;
        end
        default: begin
          if      (i_req[SRC_RR]) o_grant[SRC_RR] = 1'b1;
          else if (i_req[SRC_RQ]) o_grant[SRC_RQ] = 1'b1;
          else if (i_req[SRC_WR]) o_grant[SRC_WR] = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/etx_arbiter.sv
// TX scheduler: gates rr/rq/wr by remote pushback, round-robins them and
// presents one registered packet at a time to the serializer.
module etx_arbiter #(
  parameter int PW = etx_pkg::PW,
  parameter int CW = etx_pkg::CW
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          emrr_access,
  input  logic [PW-1:0] emrr_packet,
  output logic          emrr_wait,
  input  logic          emrq_access,
  input  logic [PW-1:0] emrq_packet,
  output logic          emrq_wait,
  input  logic          emwr_access,
  input  logic [PW-1:0] emwr_packet,
  output logic          emwr_wait,
  output logic          etx_access,
  output logic [PW-1:0] etx_packet,
  input  logic          etx_wait,
  input  logic          txi_wr_wait,
  input  logic          txi_rd_wait,
  input  logic [CW-1:0] ecfg_tx_ctrlmode,
  input  logic          ecfg_elink_disable
);

  localparam logic [1:0] RR = etx_pkg::SRC_RR;
  localparam logic [1:0] RQ = etx_pkg::SRC_RQ;
  localparam logic [1:0] WR = etx_pkg::SRC_WR;

  logic [1:0]    r_ptr;
  logic          r_access;
  logic [PW-1:0] r_packet;

  logic          w_free;
  logic [2:0]    w_req;
  logic [2:0]    w_grant;
  logic [1:0]    w_gidx;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_load;

  // Held off during reset so every requester sees wait=access.
  assign w_free = (!r_access || !etx_wait) && !reset;

  // Read responses go out as writes on the wire, so they share the write pushback.
  always_comb begin
    w_req     = '0;
    w_req[RR] = emrr_access && !txi_wr_wait;
    w_req[RQ] = emrq_access && !txi_rd_wait;
    w_req[WR] = emwr_access && !txi_wr_wait;
    if (ecfg_elink_disable) w_req = '0;
  end

  etx_rr_arb u_arb (
    .i_req   (w_req),
    .i_en    (w_free),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign emrr_wait = emrr_access && !w_grant[RR];
  assign emrq_wait = emrq_access && !w_grant[RQ];
  assign emwr_wait = emwr_access && !w_grant[WR];

  always_comb begin
    w_gidx = RR;
    if (w_grant[RQ]) w_gidx = RQ;
    if (w_grant[WR]) w_gidx = WR;
    w_sel  = ({PW{w_grant[RR]}} & emrr_packet)
           | ({PW{w_grant[RQ]}} & emrq_packet)
           | ({PW{w_grant[WR]}} & emwr_packet);
    w_load = w_sel;
    if (ecfg_tx_ctrlmode != '0) w_load[etx_pkg::CTRL_LSB +: CW] = ecfg_tx_ctrlmode;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_access <= 1'b0;
      r_packet <= '0;
      r_ptr    <= RR;
    end else if (|w_grant) begin
      r_access <= 1'b1;
      r_packet <= w_load;
      r_ptr    <= etx_pkg::ptr_after(w_gidx);
    end else if (!etx_wait) begin
      r_access <= 1'b0;
    end
  end

  assign etx_access = r_access;
  assign etx_packet = r_packet;

endmodule

// File: doc/etx_arbiter.md
# etx_arbiter

Transmit-side scheduler for the elink. Shares the single TX serializer path between three emesh packet sources: read responses (rr), read requests (rq) and writes (wr). Sources are gated by the remote pushback pins. The block applies round-robin fairness, the ecfg control-mode override and link disable, and presents one registered packet at a time to the TX serializer.

## Interface
Parameters:
- PW, 104 — emesh packet width, packed per the etx_pkg field offsets.
- CW, 4 — ctrlmode field width.

Ports:
- clk_in  in  1  TX core clock; single clock domain.
- reset  in  1  asynchronous, active-high.
- emrr_access  in  1  read-response packet valid.
- emrr_packet  in  PW  read-response packet.
- emrr_wait  out  1  read response not taken this cycle.
- emrq_access  in  1  read-request packet valid.
- emrq_packet  in  PW  read-request packet.
- emrq_wait  out  1  read request not taken this cycle.
- emwr_access  in  1  write packet valid.
- emwr_packet  in  PW  write packet.
- emwr_wait  out  1  write not taken this cycle.
- etx_access  out  1  packet valid to serializer (registered).
- etx_packet  out  PW  packet to serializer (registered).
- etx_wait  in  1  serializer cannot take packet this cycle.
- txi_wr_wait  in  1  remote write pushback, already synchronized to clk_in.
- txi_rd_wait  in  1  remote read pushback, already synchronized to clk_in.
- ecfg_tx_ctrlmode  in  CW  nonzero value overrides the packet ctrlmode field.
- ecfg_elink_disable  in  1  block new grants.

## Operation
- **Source handshake:** valid/wait. A transfer occurs when x_access & !x_wait. The source holds access and packet stable while wait is high. x_wait is combinational: x_wait = x_access & !grant_x.
- **Eligibility:**
  - rr and wr are eligible only when txi_wr_wait=0, because responses travel as writes on the wire.
  - rq is eligible only when txi_rd_wait=0.
  - No source is eligible when ecfg_elink_disable=1.
- **Slot:** a single output register (etx_access/etx_packet). It is free when etx_access=0 or etx_wait=0 (consumed this cycle). A grant is issued only when the slot is free and at least one source is both requesting and eligible.
- **Fairness:** rotating pointer ptr (2 bits, values 0=rr, 1=rq, 2=wr).
  - Search order is ptr, ptr+1, ptr+2, modulo 3.
  - After granting source i, ptr <= (i+1) mod 3. ptr is unchanged when there is no grant.
  - The value 3 is unreachable; if it is ever seen, treat it as 0.
- **Load:** the granted packet is loaded into the slot. If ecfg_tx_ctrlmode != 0, the ctrlmode field is replaced by ecfg_tx_ctrlmode. All other fields pass unchanged.
- **Drain:** if the slot is consumed and no grant occurs, etx_access <= 0. The packet register holds its last value.
- **Pushback scope:** txi_*_wait gates selection only. A packet already in the slot stays presented; stalling it is the serializer's job via etx_wait.
- **Disable:** asserting ecfg_elink_disable mid-stream blocks new grants and lets the slot drain normally. It does not flush the slot.
- **Per-cycle limits:** at most one grant per cycle. Simultaneous requests from all three sources are resolved by ptr alone.

## Timing
- **Reset values:**
  - etx_access=0, etx_packet=0, ptr=0.
  - x_wait = x_access, because no grant happens while reset is asserted.
- **Latency:** a source transfer in cycle N gives etx_access=1 with that packet in cycle N+1.
- **Throughput:** one packet per cycle when etx_wait=0. Back-to-back grants are allowed in the cycle the slot is consumed.
- **Stall:** etx_wait=1 with etx_access=1 means no grant, and all requesting sources see wait=1.
- **Mid-operation reset:** asynchronous clear of the slot and ptr. Any in-flight packet is dropped.
- **Config sampling:** ecfg_* are sampled in the grant cycle only. Changing ctrlmode does not alter a packet already in the slot.

## Structure
- **etx_pkg:**
  - PW and CW.
  - Field offsets: WRITE bit 0, DATAMODE [2:1], CTRLMODE [6:3], DSTADDR [38:7], DATA [70:39], SRCADDR [102:71]; bit 103 reserved, always 0.
  - Source index constants SRC_RR=0, SRC_RQ=1, SRC_WR=2.
- **etx_rr_arb sub-module:** 3-way round-robin core. It takes req[2:0], en (slot free) and ptr state, and outputs a one-hot grant[2:0]. Reused later on the RX side.
- **Top level:** eligibility gating, slot register, ctrlmode mux, wait generation.

## Test plan
- **Single write:** reset, then emwr_access=1 with DSTADDR=0x8080_0000, DATA=0x1234_5678 for 1 cycle, etx_wait=0 → emwr_wait=0, etx_access=1 the next cycle with an identical packet, then etx_access=0.
- **Round-robin:** all three sources request continuously, etx_wait=0 → grant order rr, rq, wr, rr, rq, wr; each source sees exactly one wait=0 cycle in every 3.
- **Pushback:** txi_wr_wait=1 with all sources requesting → only rq is granted, on consecutive cycles. Then txi_rd_wait=1 as well → no grants; etx_access falls after the slot drains.
- **Serializer stall:** etx_wait=1 for 5 cycles with a packet in the slot → etx_packet stable and all x_wait=1 throughout. On release, the next grant occurs in that same cycle.
- **Ctrlmode override:** ecfg_tx_ctrlmode=4'hA, emrq packet with CTRLMODE=0 → etx_packet[6:3]=4'hA, all other bits unchanged. With ctrlmode=0 the packet passes untouched.
- **Disable and reset:** assert ecfg_elink_disable while a slot is full and requests are pending → the slot drains and no new grants occur. Deassert, then assert reset mid-stream → etx_access=0 and ptr=0 immediately (asynchronous); the first grant after reset goes to rr.
